alu_div_seq: RTL and testbench
==============================

Name: alu_div_seq

Overview:
- Multi-cycle sequencer and datapath for RISC-V M-extension divide/remainder: DIV, DIVU, REM, REMU and the W variants.
- Replaces the single-cycle combinational divide in the EXU with a radix-2 restoring iteration, one quotient bit per cycle.
- Uses a valid/ready handshake on both sides so the pipeline stalls while it is busy.
- Divide-by-zero and signed overflow produce the results defined by the ISA.

Parameters:
- XLEN, 64, operand and result width; W ops use the low 32 bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of any operation in flight
- in_valid  in  1  request valid
- in_ready  out  1  block can accept (state IDLE and !flush)
- is_sr1_signed  in  1  treat dividend as signed
- is_sr2_signed  in  1  treat divisor as signed
- is_word  in  1  32-bit op; use sr*_data[31:0], sign-extend results to XLEN
- sr1_data  in  XLEN  dividend
- sr2_data  in  XLEN  divisor
- out_valid  out  1  results valid (state DONE)
- out_ready  in  1  consumer accepts results
- div_result  out  XLEN  quotient
- rem_result  out  XLEN  remainder

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all operand/partial registers=0, div_result=0, rem_result=0, out_valid=0. in_ready=1 once rst=1.
- Accept on the edge where in_valid && in_ready. Operands, sign flags and is_word are latched; inputs are ignored afterwards.
- Width N = 32 if is_word, else XLEN. Operands are converted to magnitudes. Negation applies only when the corresponding signed flag is set and the MSB of the N-bit operand is 1.
- States:
  - IDLE: waits for accept.
    - Divisor==0 -> DONE with quotient=all ones (N bits), remainder=dividend.
    - Signed op, dividend==most-negative N-bit value, divisor==-1 -> DONE with quotient=dividend, remainder=0.
    - Otherwise -> CALC with counter=N.
  - CALC: one restoring step per cycle. Shift {rem,quo} left 1; if rem>=divisor then subtract and set quo[0]=1. Counter decrements; at counter==1 -> FIX.
  - FIX: one cycle.
    - Quotient negated if signed and operand signs differ.
    - Remainder negated if signed and dividend negative.
    - If is_word, both results sign-extended from bit 31 (including DIVUW/REMUW).
    - Results are written to div_result/rem_result, then -> DONE.
  - DONE: out_valid=1 and results held stable. On out_ready -> IDLE (out_valid drops next cycle).
- Latency from accept edge to out_valid:
  - Normal: N+2 cycles (66 for XLEN ops, 34 for W ops).
  - Special cases: 1 cycle.
- Throughput: one op in flight. in_ready=0 in CALC/FIX/DONE; a new accept is possible the cycle after DONE exits.
- Flush: any state -> IDLE on next edge. out_valid=0 next cycle; results registers are not cleared.
  - Flush has priority over accept in the same cycle (in_ready=0 while flush=1).
  - Flush in DONE with out_ready=1: the result is treated as not consumed.
- Reset mid-operation: immediate return to the reset values above, no output pulse.
- Remainder sign always follows the dividend. Identity dividend = quotient*divisor + remainder holds for every non-special case, both widths.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the magnitude of the dividend is less than the magnitude of the divisor (nonzero divisor), skip CALC and go to FIX with quo=0, rem=|dividend|. Latency 2 cycles.
- Not defined: every non-special op takes the full N+2 cycles; no magnitude comparator is built.

Test Plan:
- DIV 64-bit: sr1=-7, sr2=2, signed both -> after 66 cycles div=-3 (0xFFFF_FFFF_FFFF_FFFD), rem=-1; out_valid held until out_ready.
- DIVU: sr1=0xFFFF_FFFF_FFFF_FFFF, sr2=0 -> div=all ones, rem=sr1, out_valid 1 cycle after accept.
- Overflow DIV: sr1=0x8000_0000_0000_0000, sr2=-1 -> div=0x8000_0000_0000_0000, rem=0, 1-cycle latency. REMW with sr1[31:0]=0x8000_0000, sr2=-1 -> rem=0, div=0xFFFF_FFFF_8000_0000.
- DIVUW: sr1=0x1234_5678_FFFF_FFFE, sr2=0x2 -> div=0x0000_0000_7FFF_FFFF, rem=0, latency 34. REMUW sr1[31:0]=0xFFFF_FFFF, sr2=0x10 -> rem=0xF.
- Flush at cycle 10 of CALC, then accept 100/7 unsigned on the next in_ready -> only second result appears, div=14, rem=2; no out_valid for the flushed op. Repeat with rst asserted mid-CALC -> all outputs 0, out_valid=0.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE with in_valid=1 -> in_ready=0, results stable, no second accept. With DIV_EARLY_OUT_EN: 3/10 -> div=0, rem=3 at latency 2.

Source files
------------

// File: rtl/alu_div_seq.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and their W variants.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|).
module alu_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_sr1_signed,
  input  logic            is_sr2_signed,
  input  logic            is_word,
  input  logic [XLEN-1:0] sr1_data,
  input  logic [XLEN-1:0] sr2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result,
  output logic [XLEN-1:0] rem_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int HW = XLEN - 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0]   N_XLEN = CW'(XLEN);
  localparam logic [CW-1:0]   N_WORD = CW'(32);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = {{HW{v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    zext32 = {{HW{1'b0}}, v};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [XLEN-1:0] remr_q, remr_d;

  logic [XLEN-1:0] op1_n, op2_n, neg1_full, neg2_full, mag1, mag2;
  logic [XLEN-1:0] ones_n, min_n, spec_div, spec_rem;
  logic            sgn1, sgn2, div0, ovf;
  logic [XLEN:0]   rem_sh;
  logic            step_ge;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] quo_w, quo_s, rem_s, fix_div, fix_rem;

  // Incoming operand decode: N-bit operands, magnitudes and special-case detection.
  always_comb begin
    op1_n     = is_word ? zext32(sr1_data[31:0]) : sr1_data;
    op2_n     = is_word ? zext32(sr2_data[31:0]) : sr2_data;
    sgn1      = is_sr1_signed && (is_word ? sr1_data[31] : sr1_data[XLEN-1]);
    sgn2      = is_sr2_signed && (is_word ? sr2_data[31] : sr2_data[XLEN-1]);
    neg1_full = (~op1_n) + ONE;
    neg2_full = (~op2_n) + ONE;
    mag1      = sgn1 ? (is_word ? zext32(neg1_full[31:0]) : neg1_full) : op1_n;
    mag2      = sgn2 ? (is_word ? zext32(neg2_full[31:0]) : neg2_full) : op2_n;
    ones_n    = is_word ? zext32(32'hFFFF_FFFF) : {XLEN{1'b1}};
    min_n     = is_word ? zext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div0      = (op2_n == ZERO);
    ovf       = is_sr1_signed && is_sr2_signed && (op1_n == min_n) && (op2_n == ones_n);
    // Divide-by-zero: quotient all ones, remainder = dividend. Overflow: quotient = dividend.
    spec_div  = div0 ? ones_n : op1_n;
    spec_rem  = div0 ? op1_n : ZERO;
    if (is_word) begin
      spec_div = sext32(spec_div[31:0]);
      spec_rem = sext32(spec_rem[31:0]);
    end else begin
      spec_div = spec_div;
      spec_rem = spec_rem;
    end
  end

  // One restoring step and the final sign fix-up of the iterated magnitudes.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    step_ge = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh[XLEN-1:0] - dvs_q;
    quo_w   = word_q ? zext32(quo_q[31:0]) : quo_q;
    quo_s   = qneg_q ? ((~quo_w) + ONE) : quo_w;
    rem_s   = rneg_q ? ((~rem_q) + ONE) : rem_q;
    fix_div = word_q ? sext32(quo_s[31:0]) : quo_s;
    fix_rem = word_q ? sext32(rem_s[31:0]) : rem_s;
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    word_d  = word_q;
    div_d   = div_q;
    remr_d  = remr_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            dvs_d  = mag2;
            qneg_d = sgn1 ^ sgn2;
            rneg_d = sgn1;
            word_d = is_word;
            if (div0 || ovf) begin
              div_d   = spec_div;
              remr_d  = spec_rem;
              state_d = ST_DONE;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag1 < mag2) begin
              quo_d   = ZERO;
              rem_d   = mag1;
              state_d = ST_FIX;
            end
`endif
            else begin
              // W ops are left-aligned so the shift always feeds from the top bit.
              quo_d   = is_word ? {mag1[31:0], {HW{1'b0}}} : mag1;
              rem_d   = ZERO;
              cnt_d   = is_word ? N_WORD : N_XLEN;
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_d = step_ge ? rem_sub : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ge};
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_FIX: begin
          div_d   = fix_div;
          remr_d  = fix_rem;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      rem_q   <= ZERO;
      quo_q   <= ZERO;
      dvs_q   <= ZERO;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      word_q  <= 1'b0;
      div_q   <= ZERO;
      remr_q  <= ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      word_q  <= word_d;
      div_q   <= div_d;
      remr_q  <= remr_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE) && !flush;
  assign out_valid  = (state_q == ST_DONE);
  assign div_result = div_q;
  assign rem_result = remr_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: reference model pushes expected results, DONE pops and compares.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_sr1_signed = 1'b0;
  logic        is_sr2_signed = 1'b0;
  logic        is_word = 1'b0;
  logic [63:0] sr1_data = 64'd0;
  logic [63:0] sr2_data = 64'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] div_result;
  logic [63:0] rem_result;

  always #5 clk = ~clk;

  alu_div_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_sr1_signed(is_sr1_signed), .is_sr2_signed(is_sr2_signed), .is_word(is_word),
    .sr1_data(sr1_data), .sr2_data(sr2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .div_result(div_result), .rem_result(rem_result)
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input bit s1, input bit s2, input bit w,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [31:0] a32, b32, q32, r32;
    bit          sp;
    sp = 1'b0;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; sp = 1'b1;
      end else if (s1 && s2 && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; sp = 1'b1;
      end else if (s1 && s2) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      e.q   = {{32{q32[31]}}, q32};
      e.r   = {{32{r32[31]}}, r32};
      e.lat = sp ? 1 : 34;
    end else begin
      if (b == 64'd0) begin
        e.q = 64'hFFFF_FFFF_FFFF_FFFF; e.r = a; sp = 1'b1;
      end else if (s1 && s2 && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        e.q = a; e.r = 64'd0; sp = 1'b1;
      end else if (s1 && s2) begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.lat = sp ? 1 : 66;
    end
`ifdef DIV_EARLY_OUT_EN
    begin
      logic [63:0] an, bn, ma, mb;
      an = w ? {32'd0, a[31:0]} : a;
      bn = w ? {32'd0, b[31:0]} : b;
      ma = (s1 && (w ? a[31] : a[63])) ? (w ? {32'd0, 32'(-a[31:0])} : -a) : an;
      mb = (s2 && (w ? b[31] : b[63])) ? (w ? {32'd0, 32'(-b[31:0])} : -b) : bn;
      if (!sp && ma < mb) e.lat = 2;
    end
`endif
    return e;
  endfunction

  // Drive one op, wait for DONE, optionally hold back-pressure, then compare and consume.
  task automatic run_op(input string tag, input bit s1, input bit s2, input bit w,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(s1, s2, w, a, b));
    is_sr1_signed = s1;
    is_sr2_signed = s2;
    is_word       = w;
    sr1_data      = a;
    sr2_data      = b;
    in_valid      = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    sr1_data = {$urandom, $urandom};
    sr2_data = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    if (hold > 0) begin
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_bp_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_bp_out_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_bp_div"}, div_result, e.q);
      end
      in_valid = 1'b0;
    end
    chk({tag, "_div"}, div_result, e.q);
    chk({tag, "_rem"}, rem_result, e.r);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  // Start an op and let it run for a number of cycles without consuming it.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input int cycles);
    is_sr1_signed = 1'b0;
    is_sr2_signed = 1'b0;
    is_word       = 1'b0;
    sr1_data      = a;
    sr2_data      = b;
    in_valid      = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (cycles) tick();
  endtask

  initial begin
    int n_ov;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (2) tick();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_div", div_result, 64'd0);
    chk("reset_rem", rem_result, 64'd0);
    rst = 1'b1;
    tick();
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    run_op("div_neg7_2", 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 20);
    run_op("divu_by0", 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op("div_ovf", 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remw_ovf", 1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("divuw", 1'b0, 1'b0, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd2, 0);
    run_op("remuw", 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 0);
    run_op("divw_signed", 1'b1, 1'b1, 1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    run_op("div_neg100_7", 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0);
    run_op("divw_by0", 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'hAAAA_0000_0000_0000, 0);
    run_op("divu_3_10", 1'b0, 1'b0, 1'b0, 64'd3, 64'd10, 0);

    // Flush mid-iteration: the aborted op must never produce a result.
    start_op(64'd1000, 64'd3, 10);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    run_op("after_flush", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 0);

    // Reset mid-iteration clears results and suppresses any output.
    start_op(64'd1000, 64'd3, 10);
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_div", div_result, 64'd0);
    chk("rst_mid_rem", rem_result, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    n_ov = 0;
    repeat (70) begin
      tick();
      if (out_valid) n_ov++;
    end
    chk("rst_mid_no_output", 64'(n_ov), 64'd0);

    for (int i = 0; i < 8; i++) begin
      bit          s, w;
      logic [63:0] a, b;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 5));
      else b = {$urandom, $urandom} >> $urandom_range(0, 60);
      run_op("rand", s, s, w, a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
